// File: rtl/neo_buf_pkg.sv
// Shared types, lag clamping and width helpers for the NEO sample buffer.
// The optional psi output is enabled with the NEO_BUF_ENERGY_EN macro.
package neo_buf_pkg;

   localparam int DEF_N = 16;

   // Default-width sample type; parameterised modules derive their own from N.
   typedef logic signed [DEF_N-1:0] sample_t;

   function automatic int kw_f(input int kmax);
      return $clog2(kmax + 1);
   endfunction

   function automatic int fill_w_f(input int kmax);
      return $clog2(2 * kmax + 1);
   endfunction

   function automatic int psi_w_f(input int n);
      return 2 * n + 1;
   endfunction

   localparam int PSI_W = psi_w_f(DEF_N);

   // A requested lag of 0 means 1; anything above kmax saturates.
   function automatic int lag_clamp(input int k_req, input int kmax);
      if (k_req < 1)
         return 1;
      else if (k_req > kmax)
         return kmax;
      return k_req;
   endfunction

endpackage

// File: rtl/neo_ring_ram.sv
// M x N sample ring: one synchronous write port, two asynchronous read ports
// used for the x[n-k] and x[n-2k] taps.
module neo_ring_ram #(
   parameter int N  = 16,
   parameter int M  = 16,
   localparam int AW = $clog2(M)
) (
   input  logic                Clk,
   input  logic                we,
   input  logic [AW-1:0]       waddr,
   input  logic signed [N-1:0] wdata,
   input  logic [AW-1:0]       raddr_a,
   output logic signed [N-1:0] rdata_a,
   input  logic [AW-1:0]       raddr_b,
   output logic signed [N-1:0] rdata_b
);

   logic signed [N-1:0] mem [M];

   // NOTE: the storage array has no reset; the fill counter upstream guarantees
   // no slot is read before it has been written in the current stream.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge Clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/neo_sample_buffer.sv
// Circular sample buffer producing (x[n-2k], x[n-k], x[n]) with valid/ready flow
// control, flush and fill tracking. NEO_BUF_ENERGY_EN adds the registered psi output.
module neo_sample_buffer
   import neo_buf_pkg::*;
#(
   parameter int N    = 16,
   parameter int M    = 16,
   parameter int KMAX = 4,
   localparam int KW  = kw_f(KMAX),
   localparam int FW  = fill_w_f(KMAX),
   localparam int PW  = psi_w_f(N),
   localparam int AW  = $clog2(M)
) (
   input  logic                Clk,
   input  logic                reset,
   input  logic [KW-1:0]       k_sel,
   input  logic                flush,
   input  logic                in_valid,
   input  logic signed [N-1:0] in_data,
   output logic                in_ready,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [N-1:0] x_prev,
   output logic signed [N-1:0] x_cur,
   output logic signed [N-1:0] x_next,
   output logic [FW-1:0]       fill
`ifdef NEO_BUF_ENERGY_EN
   ,
   output logic signed [PW-1:0] psi
`endif
);

   typedef logic signed [N-1:0] smp_t;

   localparam logic [FW-1:0] FILL_MAX = FW'(2 * KMAX);

   logic [KW-1:0] k_q;
   logic [KW-1:0] k_req;
   logic [AW-1:0] wptr;
   logic [AW-1:0] addr_k;
   logic [AW-1:0] addr_2k;
   smp_t          rd_k;
   smp_t          rd_2k;
   logic          accept;
   logic          restart;
   logic          tap_ok;
   logic          load;

   // A lag change invalidates the history exactly like an explicit flush.
   assign k_req   = KW'(lag_clamp(int'(k_sel), KMAX));
   assign restart = flush || (k_req != k_q);

   assign in_ready = !reset && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // When no restart is pending k_q already equals the requested lag.
   assign tap_ok  = (fill >= FW'(2 * int'(k_q)));
   assign load    = accept && tap_ok && !restart;

   assign addr_k  = wptr - AW'(k_q);
   assign addr_2k = wptr - AW'(2 * int'(k_q));

   neo_ring_ram #(
      .N (N),
      .M (M)
   ) u_ring (
      .Clk     (Clk),
      .we      (accept),
      .waddr   (wptr),
      .wdata   (in_data),
      .raddr_a (addr_k),
      .rdata_a (rd_k),
      .raddr_b (addr_2k),
      .rdata_b (rd_2k)
   );

   always_ff @(posedge Clk or posedge reset) begin
      if (reset) begin
         k_q       <= KW'(1);
         wptr      <= '0;
         fill      <= '0;
         out_valid <= 1'b0;
         x_prev    <= '0;
         x_cur     <= '0;
         x_next    <= '0;
      end else begin
         k_q <= k_req;

         if (accept)
            wptr <= wptr + AW'(1);

         if (restart) begin
            // A sample accepted alongside the flush opens the new stream.
            fill      <= accept ? FW'(1) : '0;
            out_valid <= 1'b0;
         end else begin
            if (accept && (fill != FILL_MAX))
               fill <= fill + FW'(1);
            if (load)
               out_valid <= 1'b1;
            else if (out_ready)
               out_valid <= 1'b0;
         end

         if (load) begin
            x_prev <= rd_2k;
            x_cur  <= rd_k;
            x_next <= in_data;
         end
      end
   end

`ifdef NEO_BUF_ENERGY_EN
   logic signed [PW-1:0] e_prev;
   logic signed [PW-1:0] e_cur;
   logic signed [PW-1:0] e_next;
   logic signed [PW-1:0] psi_d;

   // Operands are sign-extended to full width first so nothing is truncated.
   always_comb begin
      e_prev = PW'(rd_2k);
      e_cur  = PW'(rd_k);
      e_next = PW'(in_data);
      psi_d  = e_cur * e_cur - e_prev * e_next;
   end

   always_ff @(posedge Clk or posedge reset) begin
      if (reset)
         psi <= '0;
      else if (load)
         psi <= psi_d;
   end
`endif

endmodule

// File: tb/tb_neo_sample_buffer.sv
// Directed self-checking bench for neo_sample_buffer (N=16, M=16, KMAX=4).
// Exercises psi checks when NEO_BUF_ENERGY_EN is defined.
module tb_neo_sample_buffer;
   import neo_buf_pkg::*;

   localparam int N    = 16;
   localparam int M    = 16;
   localparam int KMAX = 4;
   localparam int KW   = kw_f(KMAX);
   localparam int FW   = fill_w_f(KMAX);

   logic                Clk;
   logic                reset;
   logic [KW-1:0]       k_sel;
   logic                flush;
   logic                in_valid;
   logic signed [N-1:0] in_data;
   logic                in_ready;
   logic                out_valid;
   logic                out_ready;
   logic signed [N-1:0] x_prev;
   logic signed [N-1:0] x_cur;
   logic signed [N-1:0] x_next;
   logic [FW-1:0]       fill;
`ifdef NEO_BUF_ENERGY_EN
   logic signed [2*N:0] psi;
`endif

   int total = 0;
   int bad   = 0;

   neo_sample_buffer #(
      .N    (N),
      .M    (M),
      .KMAX (KMAX)
   ) dut (
      .Clk       (Clk),
      .reset     (reset),
      .k_sel     (k_sel),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .x_prev    (x_prev),
      .x_cur     (x_cur),
      .x_next    (x_next),
      .fill      (fill)
`ifdef NEO_BUF_ENERGY_EN
      ,
      .psi       (psi)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
   endtask

   task automatic push(input int v);
      in_valid = 1'b1;
      in_data  = N'(v);
      cyc();
   endtask

   task automatic idle();
      in_valid = 1'b0;
      cyc();
   endtask

   task automatic exp_taps(input string tag, input int p, input int c, input int n);
      longint exp_psi;
      exp_psi = longint'(c) * c - longint'(p) * n;
      check({tag, ".ov"},   out_valid, 64'd1);
      check({tag, ".prev"}, x_prev, p);
      check({tag, ".cur"},  x_cur, c);
      check({tag, ".next"}, x_next, n);
`ifdef NEO_BUF_ENERGY_EN
      check({tag, ".psi"},  psi, exp_psi);
`else
      if (exp_psi == 64'sd0) check({tag, ".next_nz"}, x_next, n);
`endif
   endtask

   initial begin
      reset     = 1'b1;
      k_sel     = KW'(1);
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;

      // Reset values
      cyc();
      check("rst.in_ready", in_ready, 0);
      check("rst.ov", out_valid, 0);
      check("rst.fill", fill, 0);
      check("rst.prev", x_prev, 0);
      check("rst.cur", x_cur, 0);
      check("rst.next", x_next, 0);
`ifdef NEO_BUF_ENERGY_EN
      check("rst.psi", psi, 0);
`endif
      reset = 1'b0;
      #1;
      check("rel.in_ready", in_ready, 1);

      // Fill-up at k=1
      push(1);
      check("k1.s1.ov", out_valid, 0);
      check("k1.s1.fill", fill, 1);
      push(2);
      check("k1.s2.ov", out_valid, 0);
      check("k1.s2.fill", fill, 2);
      push(3);
      exp_taps("k1.t1", 1, 2, 3);
      push(4);
      exp_taps("k1.t2", 2, 3, 4);
      idle();
      check("k1.drain.ov", out_valid, 0);

      // Lag change to 4 restarts the stream
      k_sel = KW'(4);
      idle();
      check("k4.fill", fill, 0);
      check("k4.ov", out_valid, 0);

      // Ramp 0..40 at k=4 crosses the 15->0 pointer wrap twice
      for (int n = 0; n <= 40; n++) begin
         push(n);
         if (n >= 8)
            exp_taps($sformatf("wrap%0d", n), n - 8, n - 4, n);
         else
            check($sformatf("wrap%0d.ov", n), out_valid, 0);
         check($sformatf("wrap%0d.fill", n), fill, (n + 1 < 8) ? n + 1 : 8);
      end
      idle();
      check("wrap.drain.ov", out_valid, 0);

      // Backpressure: taps hold and input stalls for 5 cycles
      push(100);
      exp_taps("bp.t0", 33, 37, 100);
      in_data   = N'(101);
      out_ready = 1'b0;
      #1;
      check("bp.in_ready_drop", in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check($sformatf("bp.hold%0d.in_ready", i), in_ready, 0);
         exp_taps($sformatf("bp.hold%0d", i), 33, 37, 100);
         check($sformatf("bp.hold%0d.fill", i), fill, 8);
      end
      out_ready = 1'b1;
      #1;
      check("bp.release.in_ready", in_ready, 1);
      cyc();
      exp_taps("bp.t1", 34, 38, 101);
      push(102);
      exp_taps("bp.t2", 35, 39, 102);
      push(103);
      exp_taps("bp.t3", 36, 40, 103);
      push(104);
      exp_taps("bp.t4", 37, 100, 104);
      idle();

      // k=2 stream, then flush with a simultaneous accept of 7
      k_sel = KW'(2);
      idle();
      check("k2.fill", fill, 0);
      for (int v = 10; v <= 13; v++) begin
         push(v);
         check($sformatf("k2.s%0d.ov", v), out_valid, 0);
      end
      push(14);
      exp_taps("k2.t14", 10, 12, 14);
      push(15);
      exp_taps("k2.t15", 11, 13, 15);
      flush = 1'b1;
      push(7);
      flush = 1'b0;
      check("fl.ov", out_valid, 0);
      check("fl.fill", fill, 1);
      push(8);
      check("fl.s8.ov", out_valid, 0);
      push(9);
      check("fl.s9.ov", out_valid, 0);
      push(10);
      check("fl.s10.ov", out_valid, 0);
      check("fl.s10.fill", fill, 4);
      push(11);
      exp_taps("fl.t11", 7, 9, 11);
      push(12);
      exp_taps("fl.t12", 8, 10, 12);

      // k 2->3 mid-stream: the sample alongside the change opens the new stream
      k_sel = KW'(3);
      push(20);
      check("k3.s20.ov", out_valid, 0);
      check("k3.s20.fill", fill, 1);
      for (int v = 21; v <= 25; v++) begin
         push(v);
         check($sformatf("k3.s%0d.ov", v), out_valid, 0);
      end
      push(26);
      exp_taps("k3.t26", 20, 23, 26);

      // k_sel=0 behaves as k=1
      k_sel = KW'(0);
      idle();
      check("k0.fill", fill, 0);
      push(30);
      push(31);
      check("k0.s31.ov", out_valid, 0);
      push(32);
      exp_taps("k0.t32", 30, 31, 32);

      // k_sel=7 clamps to 4; re-selecting 4 afterwards is not a change
      k_sel = KW'(7);
      idle();
      check("k7.fill", fill, 0);
      for (int v = 50; v <= 57; v++) push(v);
      check("k7.s57.ov", out_valid, 0);
      check("k7.s57.fill", fill, 8);
      push(58);
      exp_taps("k7.t58", 50, 54, 58);
      k_sel = KW'(4);
      push(59);
      exp_taps("k7.t59", 51, 55, 59);
      check("k7.t59.fill", fill, 8);

      // Reset while a triple is pending under backpressure
      out_ready = 1'b0;
      idle();
      exp_taps("mr.pending", 51, 55, 59);
      #2;
      reset = 1'b1;
      #1;
      check("mr.ov", out_valid, 0);
      check("mr.in_ready", in_ready, 0);
      check("mr.fill", fill, 0);
      check("mr.prev", x_prev, 0);
      check("mr.cur", x_cur, 0);
      check("mr.next", x_next, 0);
`ifdef NEO_BUF_ENERGY_EN
      check("mr.psi", psi, 0);
`endif
      out_ready = 1'b1;
      in_valid  = 1'b1;
      cyc();
      check("mr.hold.in_ready", in_ready, 0);
      check("mr.hold.fill", fill, 0);
      in_valid = 1'b0;
      k_sel    = KW'(1);
      reset    = 1'b0;
      #1;
      push(1);
      push(2);
      check("mr.s2.ov", out_valid, 0);
      push(3);
      exp_taps("mr.t3", 1, 2, 3);
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
